// File: rtl/fmap_pad_ctrl.sv
// rtl/fmap_pad_ctrl.sv - frame sequencer for the zero-padded feature-map buffer
module fmap_pad_ctrl #(
  parameter int WIDTH  = 9,
  parameter int DIM    = 30,
  parameter int PAD    = 1,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int INNER = DIM - 2 * PAD;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DIM * DIM - 1);
  localparam logic [ADDR_W-1:0] INNER_LAST = ADDR_W'(INNER - 1);
  localparam logic [ADDR_W-1:0] PAD_A      = ADDR_W'(PAD);
  localparam logic [ADDR_W-1:0] DIM_A      = ADDR_W'(DIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SCAN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] row_cnt;
  logic [ADDR_W-1:0] col_cnt;
  logic [ADDR_W-1:0] scan_cnt;
  logic [ADDR_W-1:0] load_addr;
  logic              accept;
  logic              issue;
  logic              load_end;

  // Interior pixel (r,c) lands one border width in from the buffer edge.
  assign load_addr = (row_cnt + PAD_A) * DIM_A + col_cnt + PAD_A;
  assign accept    = in_ready & in_valid;
  assign issue     = mem_re;
  assign load_end  = (row_cnt == INNER_LAST) && (col_cnt == INNER_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and buffer-port decode from state and counters.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_raddr = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr;
          mem_wdata = in_data;
          if (load_end) begin
            state_nxt = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        busy      = 1'b1;
        mem_re    = out_ready;
        mem_raddr = scan_cnt;
        if (out_ready && (scan_cnt == LAST_ADDR)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Clear, interior row/col and scan counters; each wraps to 0 at its phase end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt  <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      scan_cnt <= '0;
    end else begin
      if (state == S_CLEAR) begin
        clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
      end
      if (accept) begin
        if (col_cnt == INNER_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == INNER_LAST) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (issue) begin
        scan_cnt <= (scan_cnt == LAST_ADDR) ? '0 : scan_cnt + 1'b1;
      end
    end
  end

  // Read data qualifiers follow the one-cycle buffer read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= mem_re;
      out_last  <= mem_re && (mem_raddr == LAST_ADDR);
    end
  end

endmodule

// File: doc/fmap_pad_ctrl.md
# fmap_pad_ctrl

Sequencer for the 30x30 padded feature-map buffer in the conv path. One frame: zero-clear the whole buffer, load a 28x28 pixel stream into the interior (1-pixel zero border), then read all 900 locations in raster order to the conv window generator. It owns every write and read port of the buffer, so the buffer needs no other control.

## Interface
- WIDTH, 9, pixel width
- DIM, 30, padded buffer edge length; interior edge is DIM-2*PAD
- PAD, 1, border width
- ADDR_W, 10, buffer address width (ceil(log2(DIM*DIM)))
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame start request; sampled only in IDLE
- in_valid  in  1  input pixel valid
- in_data  in  WIDTH  input pixel, raster order, 28x28
- in_ready  out  1  controller accepts a pixel this cycle
- mem_we  out  1  buffer write enable
- mem_waddr  out  ADDR_W  buffer write address, row*DIM+col
- mem_wdata  out  WIDTH  buffer write data
- mem_re  out  1  buffer read enable; buffer read latency is 1 cycle
- mem_raddr  out  ADDR_W  buffer read address
- out_ready  in  1  downstream allows a read issue this cycle
- out_valid  out  1  buffer read data valid this cycle (mem_re delayed 1)
- out_last  out  1  with out_valid, marks address DIM*DIM-1
- busy  out  1  high in CLEAR, LOAD, SCAN
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, CLEAR, LOAD, SCAN, DONE. Reset -> IDLE, all counters 0.
- IDLE: start=1 -> CLEAR. No other state samples start; start during a frame is ignored.
- CLEAR: mem_we=1, mem_wdata=0, mem_waddr=clr_cnt; clr_cnt 0..DIM*DIM-1, one address per cycle. Cycle with clr_cnt=DIM*DIM-1 -> LOAD.
- LOAD: in_ready=1. On in_valid&in_ready, same cycle: mem_we=1, mem_wdata=in_data, mem_waddr=(r+PAD)*DIM+(c+PAD). r,c are interior counters; c wraps at DIM-2*PAD-1 and increments r. The accept at r=c=DIM-2*PAD-1 (784th pixel) -> SCAN. No accept -> mem_we=0.
- SCAN: mem_re=out_ready, mem_raddr=scan_cnt; scan_cnt increments on each issue. An issue at DIM*DIM-1 -> DONE.
- DONE: done=1, busy=0, one cycle -> IDLE.
- out_valid = mem_re registered. out_last = (mem_re & mem_raddr==DIM*DIM-1) registered. Downstream must accept data in the out_valid cycle; out_ready gates issue only.
- mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, in_ready, busy, done are combinational decodes of state and counters (in_data and out_ready feed through). No combinational path from in_valid to in_ready.
- Outside CLEAR/LOAD: mem_we=0, mem_waddr=0, mem_wdata=0. Outside SCAN: mem_re=0, mem_raddr=0.
- Output stream, address p=R*DIM+C: 0 if R or C is in {0, DIM-1}; otherwise input pixel (R-1)*28+(C-1).

## Timing
- Reset values: in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_re=0, mem_raddr=0, out_valid=0, out_last=0, busy=0, done=0.
- start high at edge E0 -> CLEAR for exactly 900 cycles after E0, addresses 0..899 -> in_ready high in the next cycle.
- LOAD length = 784 + number of in_valid=0 cycles. SCAN length = 900 + number of out_ready=0 cycles.
- Minimum frame, start edge to done cycle: 900+784+900 cycles = 2584; done is visible in cycle 2585.
- The last out_valid/out_last (addr 899) coincides with the done cycle.
- start held high continuously: next frame begins the cycle after DONE (IDLE lasts 1 cycle).
- Async reset mid-frame: outputs go to reset values immediately, FSM goes to IDLE. Buffer contents are not touched; the next frame's CLEAR removes stale data. A pending out_valid is dropped.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> every output 0 without waiting for a clock edge; after release, idle 10 cycles with start=0 -> busy stays 0.
- Full frame, ramp input in_data=k mod 512, in_valid always 1, out_ready always 1 -> 900 out_valid beats; border = 0; beat 31 = 0 and beat 898 = 0; interior (1,1)=0, (1,2)=1, (28,28)=783; out_last only on beat 900; done in cycle 2585.
- Backpressure: in_valid random 50%, out_ready random 50% -> same 900-value stream as the full-frame test; no write without a handshake; raddr never skips or repeats.
- start pulsed during CLEAR, LOAD and SCAN -> ignored; exactly one done per frame.
- Reset during LOAD after 400 pixels, then a full frame with all pixels 0x1FF -> interior all 0x1FF, border all 0 (no stale data).
- Back-to-back frames with start held high: frame 1 ramp, frame 2 constant 5 -> frame-2 interior all 5; second CLEAR starts 1 cycle after the first done.
